// File: rtl/color_pkg.sv
// Shared color definitions: drawing color codes, the 12-bit VGA RGB
// type and the code-to-RGB palette used by the display path.
package color_pkg;

    localparam logic [2:0] COLOR_BLACK  = 3'b000;
    localparam logic [2:0] COLOR_RED    = 3'b001;
    localparam logic [2:0] COLOR_ORANGE = 3'b010;
    localparam logic [2:0] COLOR_YELLOW = 3'b011;
    localparam logic [2:0] COLOR_GREEN  = 3'b100;
    localparam logic [2:0] COLOR_BLUE   = 3'b101;
    localparam logic [2:0] COLOR_PURPLE = 3'b110;
    localparam logic [2:0] COLOR_WHITE  = 3'b111;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12;

    // Cursor blink phase; SHOW means the inverted cursor is drawn.
    typedef enum logic {
        BLINK_HIDE = 1'b0,
        BLINK_SHOW = 1'b1
    } blink_state_t;

    // Map a drawing color code to its VGA channel levels.
    function automatic rgb12 palette(input logic [2:0] code);
        rgb12 c;
        case (code)
            COLOR_BLACK:  c = '{r: 4'h0, g: 4'h0, b: 4'h0};
            COLOR_RED:    c = '{r: 4'hF, g: 4'h0, b: 4'h0};
            COLOR_ORANGE: c = '{r: 4'hF, g: 4'h8, b: 4'h0};
            COLOR_YELLOW: c = '{r: 4'hF, g: 4'hF, b: 4'h0};
            COLOR_GREEN:  c = '{r: 4'h0, g: 4'hF, b: 4'h0};
            COLOR_BLUE:   c = '{r: 4'h0, g: 4'h0, b: 4'hF};
            COLOR_PURPLE: c = '{r: 4'h8, g: 4'h0, b: 4'hF};
            default:      c = '{r: 4'hF, g: 4'hF, b: 4'hF};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/blink_timer.sv
// Cursor blink timer: counts frame starts (leading edge of vsync) and
// flips the SHOW/HIDE phase every BLINK_FRAMES frames.
module blink_timer
    import color_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic        SYNC_IDLE    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pixel_en,
    input  logic vsync_in,
    output logic blink_on
);

    localparam logic [7:0] LAST_FRAME = 8'(BLINK_FRAMES - 1);

    blink_state_t state_reg, state_next;
    logic [7:0]   frame_cnt_reg, frame_cnt_next;
    logic         vsync_prev_reg;
    logic         frame_start;

    // A frame starts when vsync leaves its idle level; a long pulse counts once
    // because the previous sample is no longer idle after the first tick.
    assign frame_start = pixel_en && (vsync_prev_reg == SYNC_IDLE) && (vsync_in != SYNC_IDLE);

    // Next-state: advance the frame counter and toggle phase on wrap.
    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        if (frame_start) begin
            if (frame_cnt_reg == LAST_FRAME) begin
                frame_cnt_next = 8'd0;
                state_next     = (state_reg == BLINK_SHOW) ? BLINK_HIDE : BLINK_SHOW;
            end else begin
                frame_cnt_next = frame_cnt_reg + 8'd1;
            end
        end
    end

    // State, counter and vsync history; history only advances on pixel ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= BLINK_SHOW;
            frame_cnt_reg  <= 8'd0;
            vsync_prev_reg <= SYNC_IDLE;
        end else begin
            state_reg     <= state_next;
            frame_cnt_reg <= frame_cnt_next;
            if (pixel_en) begin
                vsync_prev_reg <= vsync_in;
            end
        end
    end

    assign blink_on = (state_reg == BLINK_SHOW);

endmodule

// File: rtl/vga_color_decoder.sv
// Display-path color decoder: two-stage pixel pipeline turning frame-buffer
// color codes into VGA RGB with a blinking inverted cursor, syncs kept aligned.
module vga_color_decoder
    import color_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic        SYNC_IDLE    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pixel_en,
    input  logic [2:0] color_code,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       cursor_hit,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync,
    output logic       vsync,
    output logic       blink_on
);

    // Stage 1: raw pixel attributes
    logic [2:0] s1_code_reg;
    logic       s1_video_reg;
    logic       s1_cursor_reg;
    logic       s1_hsync_reg;
    logic       s1_vsync_reg;

    // Stage 2: driven pins
    rgb12       rgb_reg;
    rgb12       rgb_next;
    logic       hsync_reg;
    logic       vsync_reg;

    logic [11:0] pal_bits;
    logic [11:0] inv_bits;

    blink_timer #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .SYNC_IDLE    (SYNC_IDLE)
    ) u_blink_timer (
        .clk      (clk),
        .rst      (rst),
        .pixel_en (pixel_en),
        .vsync_in (vsync_in),
        .blink_on (blink_on)
    );

    assign pal_bits = palette(s1_code_reg);

    // Cursor color is the per-bit complement of the palette entry.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_invert
            assign inv_bits[gi] = ~pal_bits[gi];
        end
    endgenerate

    // Blanking beats cursor, cursor (when visible) beats plain palette.
    always_comb begin
        rgb_next = pal_bits;
        if (!s1_video_reg) begin
            rgb_next = '0;
        end else if (s1_cursor_reg && blink_on) begin
            rgb_next = inv_bits;
        end
    end

    // Both pipeline stages advance together on pixel ticks; reset overrides.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_code_reg   <= COLOR_BLACK;
            s1_video_reg  <= 1'b0;
            s1_cursor_reg <= 1'b0;
            s1_hsync_reg  <= SYNC_IDLE;
            s1_vsync_reg  <= SYNC_IDLE;
            rgb_reg       <= '0;
            hsync_reg     <= SYNC_IDLE;
            vsync_reg     <= SYNC_IDLE;
        end else if (pixel_en) begin
            s1_code_reg   <= color_code;
            s1_video_reg  <= video_on;
            s1_cursor_reg <= cursor_hit;
            s1_hsync_reg  <= hsync_in;
            s1_vsync_reg  <= vsync_in;
            rgb_reg       <= rgb_next;
            hsync_reg     <= s1_hsync_reg;
            vsync_reg     <= s1_vsync_reg;
        end
    end

    assign vga_r = rgb_reg.r;
    assign vga_g = rgb_reg.g;
    assign vga_b = rgb_reg.b;
    assign hsync = hsync_reg;
    assign vsync = vsync_reg;

endmodule

// File: tb/tb_vga_color_decoder.sv
// Scoreboard bench: stimulus pushes hand-computed expectations tagged with the
// pixel tick on which they must appear; a monitor pops and compares per tick.
`timescale 1ns/1ps
module tb_vga_color_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pixel_en = 1'b0;
    logic [2:0] color_code = 3'b000;
    logic       video_on = 1'b0;
    logic       hsync_in = 1'b1;
    logic       vsync_in = 1'b1;
    logic       cursor_hit = 1'b0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       hsync, vsync, blink_on;

    typedef struct {
        int          due;
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } pix_exp_t;

    typedef struct {
        int   due;
        logic blink;
    } blink_exp_t;

    pix_exp_t   pix_q[$];
    blink_exp_t blink_q[$];
    int checks = 0;
    int failures = 0;
    int tick_cnt = 0;

    vga_color_decoder #(
        .BLINK_FRAMES (3),
        .SYNC_IDLE    (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pixel_en   (pixel_en),
        .color_code (color_code),
        .video_on   (video_on),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .cursor_hit (cursor_hit),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .hsync      (hsync),
        .vsync      (vsync),
        .blink_on   (blink_on)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick_cnt);
        end
    endtask

    // One pixel tick: pixel_en high for one clk out of four.
    task automatic tick();
        @(negedge clk) pixel_en = 1'b1;
        @(negedge clk) pixel_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Drive one pixel and queue its output two ticks later; optionally
    // queue the blink phase expected right after this tick.
    task automatic pix(input logic [2:0] code, input logic von, input logic cur,
                       input logic hs, input logic vs, input logic [11:0] exp_rgb,
                       input bit chk_blink = 1'b0, input logic exp_blink = 1'b1);
        color_code = code;
        video_on   = von;
        cursor_hit = cur;
        hsync_in   = hs;
        vsync_in   = vs;
        pix_q.push_back('{due: tick_cnt + 2, rgb: exp_rgb, hs: hs, vs: vs});
        if (chk_blink)
            blink_q.push_back('{due: tick_cnt + 1, blink: exp_blink});
        $display("pixel code=%b von=%b cur=%b hs=%b vs=%b exp_rgb=%03h", code, von, cur, hs, vs, exp_rgb);
        tick();
    endtask

    // Monitor: counts pixel ticks and checks everything due on this tick.
    initial begin
        pix_exp_t   pe;
        blink_exp_t be;
        forever begin
            @(posedge clk);
            if (pixel_en && !rst) begin
                tick_cnt++;
                #1;
                while (pix_q.size() > 0 && pix_q[0].due <= tick_cnt) begin
                    pe = pix_q.pop_front();
                    check("rgb", {vga_r, vga_g, vga_b}, pe.rgb);
                    check("hsync", hsync, pe.hs);
                    check("vsync", vsync, pe.vs);
                end
                while (blink_q.size() > 0 && blink_q[0].due <= tick_cnt) begin
                    be = blink_q.pop_front();
                    check("blink_on", blink_on, be.blink);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] pal_exp [8];
        pal_exp = '{12'h000, 12'hF00, 12'hF80, 12'hFF0, 12'h0F0, 12'h00F, 12'h80F, 12'hFFF};

        // Reset state
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("reset_hsync", hsync, 1'b1);
        check("reset_vsync", vsync, 1'b1);
        check("reset_blink", blink_on, 1'b1);
        rst = 1'b0;

        // Palette walk, hsync alternating to show sync delay
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            c = 3'(i);
            pix(c, 1'b1, 1'b0, c[0], 1'b1, pal_exp[i]);
        end

        // Blanking wins over code and cursor; sync still passes
        pix(3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000);
        pix(3'b010, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000);

        // Cursor visible (SHOW): inverted colors
        pix(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 12'h07F);
        pix(3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 12'h000);

        // Frames 1..3 (frame 2 held low for two ticks); toggle to HIDE at 3
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b1);
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1'b0);
        pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);

        // Cursor hidden: plain palette color
        pix(3'b010, 1'b1, 1'b1, 1'b0, 1'b1, 12'hF80);

        // Frames 4..6; toggle back to SHOW at 6
        for (int f = 4; f <= 6; f++) begin
            pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, (f == 6) ? 1'b1 : 1'b0);
            pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
        end
        pix(3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 12'h0FF);

        // Freeze: outputs hold red, vsync wiggle while frozen is not counted
        pix(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 12'hF00);
        pix(3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 12'h00F);
        for (int k = 0; k < 10; k++) begin
            if (k == 3) vsync_in = 1'b0;
            if (k == 7) vsync_in = 1'b1;
            check("freeze_rgb", {vga_r, vga_g, vga_b}, 12'hF00);
            check("freeze_hsync", hsync, 1'b0);
            @(negedge clk);
        end

        // Frames 7..9: toggle to HIDE only at 9
        for (int f = 7; f <= 9; f++) begin
            pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, (f == 9) ? 1'b0 : 1'b1);
            pix(3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 12'h000);
        end

        // HIDE with cursor, then reset mid-frame
        pix(3'b111, 1'b1, 1'b1, 1'b0, 1'b1, 12'hFFF);
        pix(3'b010, 1'b1, 1'b1, 1'b0, 1'b0, 12'hF80);
        pix_q.delete();
        blink_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("midrst_hsync", hsync, 1'b1);
        check("midrst_vsync", vsync, 1'b1);
        check("midrst_blink", blink_on, 1'b1);
        // Reset together with pixel_en: reset wins, vsync edge ignored
        vsync_in = 1'b0;
        pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        check("rst_en_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("rst_en_vsync", vsync, 1'b1);
        check("rst_en_blink", blink_on, 1'b1);
        vsync_in = 1'b1;
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Refill: first tick shows cleared stage 1, second shows new pixel
        pix_q.push_back('{due: tick_cnt + 1, rgb: 12'h000, hs: 1'b1, vs: 1'b1});
        pix(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 12'hFF0);
        pix(3'b010, 1'b1, 1'b1, 1'b1, 1'b1, 12'h07F);
        pix(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        pix(3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
        tick();
        tick();

        check("pix_queue_drained", pix_q.size(), 0);
        check("blink_queue_drained", blink_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
